mole_round_ctrl: RTL and testbench
==================================

Name: mole_round_ctrl

Overview:
Round sequencer for the whack-a-mole game. It picks a mole position from an internal LFSR, opens a timed guess window and judges the player's guess. It emits one-cycle right/wrong pulses to the LED display block, tracks score and lives, and asserts game-over. It sits between the button debouncer/encoder and the LED and score display blocks.

Parameters:
ROUND_CYCLES, 100000000, length of the guess window in i_clk cycles (1 s at 100 MHz)
COOLDOWN_CYCLES, 100000000, pause after each judgement; matches the LED animation length
MAX_LIVES, 3, lives at game start (1..3)
LFSR_SEED, 8'hA5, LFSR value after reset and after restart (must be non-zero)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous, active-low reset
i_restart_game  in  1  synchronous start/restart pulse
i_guess_valid  in  1  one-cycle strobe: i_user_guess is valid
i_user_guess  in  3  guessed position, 1..7
o_mole_position  out  3  current mole position; 0 = no mole shown
o_user_right  out  1  one-cycle pulse: guess correct
o_user_wrong  out  1  one-cycle pulse: guess wrong or timeout
o_game_over  out  1  high while in OVER
o_round_active  out  1  high while in WAIT_GUESS
o_score  out  8  correct hits, saturating at 255
o_lives  out  2  remaining lives

Behaviour:
- Reset (async, i_rst_n=0) values:
  - state=IDLE, o_mole_position=0, pulses=0, o_game_over=0, o_round_active=0
  - o_score=0, o_lives=MAX_LIVES, LFSR=LFSR_SEED, counters=0
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Advances every cycle in every state except IDLE.
- Restart: i_restart_game has top priority in every state. On that edge: score=0, lives=MAX_LIVES, LFSR=LFSR_SEED, pulses=0, state goes to SPAWN.
- States:
  - IDLE: wait for restart. Outputs held at reset values.
  - SPAWN (1 cycle): o_mole_position=LFSR[2:0], or 3'd1 if that value is 0. Load window counter with ROUND_CYCLES-1. Go to WAIT_GUESS.
  - WAIT_GUESS: o_round_active=1; counter decrements each cycle.
    - i_guess_valid with i_user_guess==o_mole_position: o_user_right pulses the next cycle; score+1 (saturating); go to COOLDOWN.
    - i_guess_valid with a mismatch: o_user_wrong pulses the next cycle; lives-1; go to COOLDOWN.
    - Counter==0 with no guess: timeout, handled exactly like a wrong guess.
    - Guess and timeout in the same cycle: the guess is judged; the timeout is ignored.
  - COOLDOWN: o_mole_position=0; runs COOLDOWN_CYCLES cycles.
    - If lives==0 on entry, go to OVER immediately after the pulse cycle.
    - Otherwise go to SPAWN when the count finishes.
  - OVER: o_game_over=1, o_mole_position=0; score frozen. Leave only via restart.
- Judgement latency: exactly 1 cycle from the strobe to the right/wrong pulse. At most one pulse per round.
- i_guess_valid outside WAIT_GUESS is ignored; it has no effect on score, lives or pulses.
- Lives never underflow (decrement only when >0). Score saturates at 255.
- Reset asserted mid-round: everything clears immediately and no pulse is emitted.

Optional Feature:
Macro ROUND_SPEEDUP_EN.
- Defined: the window reload value is ROUND_CYCLES - (ROUND_CYCLES>>4)*min(score>>2, 12). The window shortens by 1/16 for every 4 points, floor 4/16 of ROUND_CYCLES. Computed in SPAWN.
- Undefined: the window is always ROUND_CYCLES; no divider or multiplier logic is present.

Decomposition:
- Shared package mole_pkg holds:
  - state enum (IDLE, SPAWN, WAIT_GUESS, COOLDOWN, OVER)
  - NO_MOLE=3'd0
  - SCORE_W=8, LIVES_W=2
  - the LFSR tap constant
- One sub-module: mole_lfsr (8-bit LFSR with enable and synchronous reseed, async reset). The FSM, counters and scoring stay in mole_round_ctrl.

Test Plan:
- Reset, then restart with ROUND_CYCLES=10, COOLDOWN_CYCLES=4 -> SPAWN 1 cycle later; o_mole_position in 1..7; o_round_active=1; o_lives=3; o_score=0.
- Strobe a guess equal to o_mole_position in window cycle 3 -> o_user_right=1 for exactly one cycle next clock; o_score=1; mole=0 for 4 cycles; then a new SPAWN.
- Strobe a mismatched guess -> o_user_wrong one-cycle pulse; o_lives 3->2; o_score unchanged.
- No guess for 10 cycles -> o_user_wrong pulse at timeout. Three timeouts -> o_lives=0, o_game_over=1. Further strobes ignored until restart, which gives lives=3, score=0.
- Guess strobe in the same cycle as counter==0 with a correct value -> o_user_right only, no wrong pulse. Strobe during COOLDOWN -> no effect.
- Assert i_rst_n=0 mid-WAIT_GUESS -> all outputs at reset values asynchronously, before the next edge. With the macro defined, score=8 -> window=ROUND_CYCLES-2*(ROUND_CYCLES>>4) (ROUND_CYCLES=160 -> 140 cycles).

Source files
------------

// File: rtl/mole_pkg.sv
// Shared definitions for the whack-a-mole round sequencer.
//   state_e   : round sequencer states
//   NO_MOLE   : mole position value meaning "nothing shown"
//   SCORE_W   : score register width
//   LIVES_W   : lives register width
//   LFSR_TAPS : feedback tap mask for the 8-bit Fibonacci LFSR (taps 8,6,5,4)
package mole_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSpawn,
    StWaitGuess,
    StCooldown,
    StOver
  } state_e;

  localparam logic [2:0]  NO_MOLE   = 3'd0;
  localparam int unsigned SCORE_W   = 8;
  localparam int unsigned LIVES_W   = 2;
  localparam logic [7:0]  LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/mole_lfsr.sv
// 8-bit Fibonacci LFSR used to pick mole positions.
// Ports:
//   i_clk     : clock
//   i_rst_n   : asynchronous active-low reset, loads SEED
//   i_en      : advance one step this cycle
//   i_reseed  : synchronous reload of SEED, wins over i_en
//   o_low3    : low three bits of the current LFSR value
module mole_lfsr
  import mole_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic       i_reseed,
  output logic [2:0] o_low3
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;
  logic       feedback;

  always_comb begin
    feedback = ^(lfsr_q & LFSR_TAPS);
    lfsr_d   = lfsr_q;
    if (i_reseed) begin
      lfsr_d = SEED;
    end else if (i_en) begin
      lfsr_d = {lfsr_q[6:0], feedback};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign o_low3 = lfsr_q[2:0];

endmodule

// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round sequencer: spawns a mole from an LFSR, opens a timed guess
// window, judges the guess, emits one-cycle right/wrong pulses, tracks score and
// lives and flags game over.
// Optional macro ROUND_SPEEDUP_EN: shortens the guess window by 1/16 of
// ROUND_CYCLES per 4 points scored, down to a floor of 4/16.
// Ports:
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_restart_game   : synchronous start/restart, highest priority
//   i_guess_valid    : strobe qualifying i_user_guess (1..7)
//   o_mole_position  : shown mole, 0 = none
//   o_user_right/o_user_wrong : one-cycle judgement pulses
//   o_game_over      : high in the game-over state
//   o_round_active   : high while the guess window is open
//   o_score, o_lives : saturating score, remaining lives
module mole_round_ctrl
  import mole_pkg::*;
#(
  parameter int unsigned ROUND_CYCLES    = 100000000,
  parameter int unsigned COOLDOWN_CYCLES = 100000000,
  parameter int unsigned MAX_LIVES       = 3,
  parameter logic [7:0]  LFSR_SEED       = 8'hA5
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_restart_game,
  input  logic               i_guess_valid,
  input  logic [2:0]         i_user_guess,
  output logic [2:0]         o_mole_position,
  output logic               o_user_right,
  output logic               o_user_wrong,
  output logic               o_game_over,
  output logic               o_round_active,
  output logic [SCORE_W-1:0] o_score,
  output logic [LIVES_W-1:0] o_lives
);

  localparam int unsigned MaxCycles =
      (ROUND_CYCLES > COOLDOWN_CYCLES) ? ROUND_CYCLES : COOLDOWN_CYCLES;
  localparam int unsigned CntW = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
  localparam logic [CntW-1:0]    CoolReload = CntW'(COOLDOWN_CYCLES - 1);
  localparam logic [LIVES_W-1:0] LivesInit  = LIVES_W'(MAX_LIVES);

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [2:0]         mole_q, mole_d;
  logic               right_q, right_d;
  logic               wrong_q, wrong_d;
  logic [2:0]         lfsr_low3;
  logic [CntW-1:0]    round_reload;
  logic               judge;
  logic               hit;

  mole_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_en     (state_q != StIdle),
    .i_reseed (i_restart_game),
    .o_low3   (lfsr_low3)
  );

`ifdef ROUND_SPEEDUP_EN
  localparam int unsigned Step = ROUND_CYCLES >> 4;
  logic [5:0] speed_level;
  logic [3:0] speed_sat;

  always_comb begin
    speed_level  = score_q[7:2];
    speed_sat    = (speed_level > 6'd12) ? 4'd12 : speed_level[3:0];
    round_reload = CntW'(ROUND_CYCLES - 1 - Step * 32'(speed_sat));
  end
`else
  assign round_reload = CntW'(ROUND_CYCLES - 1);
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    score_d = score_q;
    lives_d = lives_q;
    mole_d  = mole_q;
    right_d = 1'b0;
    wrong_d = 1'b0;
    // A guess in the window's last cycle is judged; the timeout is then moot.
    judge   = i_guess_valid || (cnt_q == '0);
    hit     = i_guess_valid && (i_user_guess == mole_q);

    if (i_restart_game) begin
      state_d = StSpawn;
      cnt_d   = '0;
      score_d = '0;
      lives_d = LivesInit;
      mole_d  = NO_MOLE;
    end else begin
      unique case (state_q)
        StIdle: ;
        StSpawn: begin
          mole_d  = (lfsr_low3 == NO_MOLE) ? 3'd1 : lfsr_low3;
          cnt_d   = round_reload;
          state_d = StWaitGuess;
        end
        StWaitGuess: begin
          if (judge) begin
            right_d = hit;
            wrong_d = !hit;
            if (hit) begin
              if (score_q != '1) score_d = score_q + SCORE_W'(1);
            end else if (lives_q != '0) begin
              lives_d = lives_q - LIVES_W'(1);
            end
            mole_d  = NO_MOLE;
            cnt_d   = CoolReload;
            state_d = StCooldown;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        StCooldown: begin
          // Last life gone: leave right after the pulse cycle.
          if (lives_q == '0) begin
            state_d = StOver;
          end else if (cnt_q == '0) begin
            state_d = StSpawn;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        StOver: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q   <= '0;
      score_q <= '0;
      lives_q <= LivesInit;
      mole_q  <= NO_MOLE;
      right_q <= 1'b0;
      wrong_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      score_q <= score_d;
      lives_q <= lives_d;
      mole_q  <= mole_d;
      right_q <= right_d;
      wrong_q <= wrong_d;
    end
  end

  always_comb begin
    o_round_active  = (state_q == StWaitGuess);
    o_game_over     = (state_q == StOver);
    o_mole_position = mole_q;
    o_user_right    = right_q;
    o_user_wrong    = wrong_q;
    o_score         = score_q;
    o_lives         = lives_q;
  end

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Self-checking bench for mole_round_ctrl. The reference model works on a
// timeline: a round spawned k cycles after the last restart shows the mole
// derived from the seed stepped k times; window, cooldown and game rules are
// tracked as plain integers.
module tb_mole_round_ctrl;

  localparam int unsigned RoundCycles    = 10;
  localparam int unsigned CooldownCycles = 4;
  localparam int unsigned MaxLives       = 3;
  localparam logic [7:0]  Seed           = 8'hA5;
`ifdef ROUND_SPEEDUP_EN
  localparam bit SpeedupEn = 1'b1;
`else
  localparam bit SpeedupEn = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_restart_game;
  logic        i_guess_valid;
  logic [2:0]  i_user_guess;
  logic [2:0]  o_mole_position;
  logic        o_user_right;
  logic        o_user_wrong;
  logic        o_game_over;
  logic        o_round_active;
  logic [7:0]  o_score;
  logic [1:0]  o_lives;
  logic [16:0] obs;
  logic [16:0] exp_v;

  int          checks = 0;
  int          errors = 0;
  int unsigned k = 0;
  int unsigned m_score = 0;
  int unsigned m_lives = MaxLives;

  mole_round_ctrl #(
    .ROUND_CYCLES    (RoundCycles),
    .COOLDOWN_CYCLES (CooldownCycles),
    .MAX_LIVES       (MaxLives),
    .LFSR_SEED       (Seed)
  ) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_restart_game  (i_restart_game),
    .i_guess_valid   (i_guess_valid),
    .i_user_guess    (i_user_guess),
    .o_mole_position (o_mole_position),
    .o_user_right    (o_user_right),
    .o_user_wrong    (o_user_wrong),
    .o_game_over     (o_game_over),
    .o_round_active  (o_round_active),
    .o_score         (o_score),
    .o_lives         (o_lives)
  );

  always #5 i_clk = ~i_clk;

  assign obs = {o_mole_position, o_user_right, o_user_wrong, o_game_over, o_round_active,
                o_score, o_lives};

  function automatic logic [16:0] pack(input logic [2:0] mole, input logic r, input logic w,
                                       input logic go, input logic act);
    return {mole, r, w, go, act, 8'(m_score), 2'(m_lives)};
  endfunction

  function automatic logic [2:0] exp_mole(input int unsigned steps);
    logic [7:0] v;
    v = Seed;
    for (int unsigned i = 0; i < steps; i++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    return (v[2:0] == 3'd0) ? 3'd1 : v[2:0];
  endfunction

  function automatic int unsigned window(input int unsigned score);
    int unsigned lvl;
    lvl = score / 4;
    if (lvl > 12) lvl = 12;
    return SpeedupEn ? RoundCycles - (RoundCycles / 16) * lvl : RoundCycles;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
    k++;
  endtask

  // mode 0: correct guess in window cycle j, 1: wrong guess in cycle j, 2: timeout.
  // Entered and left in a spawn cycle (or in the first game-over cycle).
  task automatic run_round(input int mode, input int unsigned j_req);
    int unsigned w, j;
    logic [2:0]  mole;
    bit          hit;
    w    = window(m_score);
    mole = exp_mole(k);
    j    = (mode == 2) ? w : j_req;
    exp_v = pack(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL spawn_cycle: got %h, expected %h", obs, exp_v);
    end
    tick();
    for (int unsigned c = 1; c <= j; c++) begin
      exp_v = pack(mole, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL window_cycle_%0d: got %h, expected %h", c, obs, exp_v);
      end
      if (c == j && mode != 2) begin
        i_guess_valid = 1'b1;
        if (mode == 0) i_user_guess = mole;
        else i_user_guess = 3'((32'(mole) - 1 + $urandom_range(1, 6)) % 7 + 1);
      end
      tick();
      i_guess_valid = 1'b0;
    end
    hit = (mode == 0);
    if (hit) begin
      if (m_score < 255) m_score++;
    end else if (m_lives > 0) begin
      m_lives--;
    end
    exp_v = pack(3'd0, hit, !hit, 1'b0, 1'b0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL judge_pulse mode%0d: got %h, expected %h", mode, obs, exp_v);
    end
    if (m_lives == 0) begin
      tick();
      exp_v = pack(3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL over_entry: got %h, expected %h", obs, exp_v);
      end
    end else begin
      for (int unsigned c = 1; c < CooldownCycles; c++) begin
        if (c == 1) begin
          i_guess_valid = 1'b1;
          i_user_guess  = 3'($urandom_range(1, 7));
        end
        tick();
        i_guess_valid = 1'b0;
        exp_v = pack(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== exp_v) begin
          errors++;
          $display("FAIL cooldown_cycle_%0d: got %h, expected %h", c + 1, obs, exp_v);
        end
      end
      tick();
    end
  endtask

  task automatic do_restart();
    i_restart_game = 1'b1;
    tick();
    i_restart_game = 1'b0;
    k       = 0;
    m_score = 0;
    m_lives = MaxLives;
    exp_v = pack(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL restart_spawn: got %h, expected %h", obs, exp_v);
    end
  endtask

  task automatic test_reset();
    i_rst_n        = 1'b0;
    i_restart_game = 1'b0;
    i_guess_valid  = 1'b0;
    i_user_guess   = 3'd0;
    repeat (2) tick();
    exp_v = pack(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL reset_values: got %h, expected %h", obs, exp_v);
    end
    i_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_guess_valid = 1'b1;
      i_user_guess  = 3'($urandom_range(1, 7));
      tick();
      i_guess_valid = 1'b0;
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL idle_ignores_guess: got %h, expected %h", obs, exp_v);
      end
    end
  endtask

  task automatic test_random_rounds();
    int mode;
    for (int i = 0; i < 12; i++) begin
      mode = int'($urandom_range(0, 2));
      if (m_lives == 1) mode = 0;
      run_round(mode, $urandom_range(1, window(m_score)));
    end
  endtask

  task automatic test_game_over();
    while (m_lives > 0) run_round(2, 0);
    for (int i = 0; i < 6; i++) begin
      i_guess_valid = 1'b1;
      i_user_guess  = 3'($urandom_range(1, 7));
      tick();
      i_guess_valid = 1'b0;
      exp_v = pack(3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL over_hold: got %h, expected %h", obs, exp_v);
      end
    end
  endtask

  task automatic test_restart_mid_round();
    logic [2:0] mole;
    run_round(0, 2);
    mole = exp_mole(k);
    tick();
    tick();
    i_restart_game = 1'b1;
    i_guess_valid  = 1'b1;
    i_user_guess   = mole;
    tick();
    i_restart_game = 1'b0;
    i_guess_valid  = 1'b0;
    k       = 0;
    m_score = 0;
    m_lives = MaxLives;
    exp_v = pack(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL restart_mid_round: got %h, expected %h", obs, exp_v);
    end
    run_round(0, 1);
  endtask

  task automatic test_score_saturation();
    do_restart();
    for (int i = 0; i < 258; i++) run_round(0, $urandom_range(1, 2));
  endtask

  task automatic test_async_reset();
    tick();
    i_rst_n = 1'b0;
    #1;
    m_score = 0;
    m_lives = MaxLives;
    exp_v = pack(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL async_reset_immediate: got %h, expected %h", obs, exp_v);
    end
    tick();
    i_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_guess_valid = 1'b1;
      i_user_guess  = 3'($urandom_range(1, 7));
      tick();
      i_guess_valid = 1'b0;
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL idle_after_reset: got %h, expected %h", obs, exp_v);
      end
    end
    do_restart();
    run_round(1, 1);
  endtask

  initial begin
    test_reset();
    do_restart();
    run_round(0, 3);
    run_round(1, $urandom_range(1, window(m_score)));
    run_round(0, window(m_score));
    run_round(2, 0);
    test_random_rounds();
    test_game_over();
    do_restart();
    run_round(0, 2);
    test_restart_mid_round();
    test_score_saturation();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
